// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg
// Shared definitions for the PLL reset sequencer:
//   - seq_state_t : 2-bit sequencer state (PLLRST, WAIT, STABLE, RUN)
//   - DEF_*       : default cycle counts and counter width
//   - DIV*_TC     : clock-enable divider terminal values
package pll_seq_pkg;

    typedef enum logic [1:0] {
        PLLRST = 2'd0,
        WAIT   = 2'd1,
        STABLE = 2'd2,
        RUN    = 2'd3
    } seq_state_t;

    localparam int DEF_PLL_RST_CYCLES      = 16;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 1048576;
    localparam int DEF_LOCK_STABLE_CYCLES  = 4096;
    localparam int DEF_CNT_W               = 21;

    // ce_12 uses only the low two bits of the divider, ce_6 all three.
    localparam logic [2:0] DIV12_TC = 3'd3;
    localparam logic [2:0] DIV6_TC  = 3'd7;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
// Two-flop synchroniser for a single asynchronous input.
// Ports:
//   clk   in  destination clock
//   rst_n in  asynchronous active-low reset (both flops clear to 0)
//   d     in  asynchronous input
//   q     out synchronised output, two clk cycles of latency
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic q_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= 1'b0;
            q_reg    <= 1'b0;
        end else begin
            meta_reg <= d;
            q_reg    <= meta_reg;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/pll_reset_seq.sv
// pll_reset_seq
// Sequences the PLL reset, qualifies the (asynchronous) lock indication and
// releases the core reset once lock has been stable for LOCK_STABLE_CYCLES.
// Also produces phase-deterministic 12 MHz / 6 MHz clock enables while running.
// Ports:
//   clk          in  48 MHz clock from the PLL
//   rst_n        in  asynchronous active-low reset
//   pll_locked   in  PLL lock, asynchronous to clk
//   soft_reset   in  level-sensitive core reset request
//   pll_rst      out reset to the PLL (high only in PLLRST)
//   core_reset   out reset to the core (low only in RUN)
//   ready        out high while in RUN
//   ce_12        out 1-in-4 clock enable
//   ce_6         out 1-in-8 clock enable
//   state        out current sequencer state (debug)
//   relock_count out number of lock losses seen in RUN, saturating at 255
module pll_reset_seq
    import pll_seq_pkg::*;
#(
    parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int CNT_W               = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       soft_reset,
    output logic       pll_rst,
    output logic       core_reset,
    output logic       ready,
    output logic       ce_12,
    output logic       ce_6,
    output logic [1:0] state,
    output logic [7:0] relock_count
);

    localparam logic [CNT_W-1:0] PLL_RST_TC = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_TC = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_TC  = CNT_W'(LOCK_STABLE_CYCLES - 1);

    logic             lk;
    seq_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       div_reg, div_next;
    logic [7:0]       relock_reg, relock_next;
    logic             pll_rst_reg, core_reset_reg, ready_reg, ce_12_reg, ce_6_reg;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (lk)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= PLLRST;
            cnt_reg        <= '0;
            div_reg        <= '0;
            relock_reg     <= '0;
            pll_rst_reg    <= 1'b1;
            core_reset_reg <= 1'b1;
            ready_reg      <= 1'b0;
            ce_12_reg      <= 1'b0;
            ce_6_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            div_reg        <= div_next;
            relock_reg     <= relock_next;
            // Outputs are decoded from the next state so they change on the
            // same edge as state_reg without a combinational output path.
            pll_rst_reg    <= (state_next == PLLRST);
            core_reset_reg <= (state_next != RUN);
            ready_reg      <= (state_next == RUN);
            ce_12_reg      <= (state_next == RUN) && (div_next[1:0] == DIV12_TC[1:0]);
            ce_6_reg       <= (state_next == RUN) && (div_next == DIV6_TC);
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg + 1'b1;
        relock_next = relock_reg;
        case (state_reg)
            PLLRST: begin
                if (cnt_reg == PLL_RST_TC) begin
                    state_next = WAIT;
                    cnt_next   = '0;
                end
            end
            WAIT: begin
                // Lock arriving on the timeout cycle wins over the retry.
                if (lk) begin
                    state_next = STABLE;
                    cnt_next   = '0;
                end else if (cnt_reg == TIMEOUT_TC) begin
                    state_next = PLLRST;
                    cnt_next   = '0;
                end
            end
            STABLE: begin
                // A lock drop wins over the terminal count.
                if (!lk) begin
                    state_next = WAIT;
                    cnt_next   = '0;
                end else if (soft_reset) begin
                    cnt_next = '0;
                end else if (cnt_reg == STABLE_TC) begin
                    state_next = RUN;
                    cnt_next   = '0;
                end
            end
            RUN: begin
                cnt_next = '0;
                if (!lk) begin
                    state_next = PLLRST;
                    if (relock_reg != 8'hFF) begin
                        relock_next = relock_reg + 1'b1;
                    end
                end else if (soft_reset) begin
                    state_next = STABLE;
                end
            end
            default: begin
                state_next = PLLRST;
                cnt_next   = '0;
            end
        endcase
    end

    // Divider only counts while staying in RUN, so every RUN entry starts
    // at phase 0 and the first ce_12 lands on the 4th RUN cycle.
    always_comb begin
        div_next = '0;
        if ((state_reg == RUN) && (state_next == RUN)) begin
            div_next = div_reg + 1'b1;
        end
    end

    assign pll_rst      = pll_rst_reg;
    assign core_reset   = core_reset_reg;
    assign ready        = ready_reg;
    assign ce_12        = ce_12_reg;
    assign ce_6         = ce_6_reg;
    assign state        = state_reg;
    assign relock_count = relock_reg;

endmodule

// File: tb/tb_pll_reset_seq.sv
module tb_pll_reset_seq;

    localparam int PR = 4;
    localparam int TO = 64;
    localparam int ST = 8;
    localparam int CW = 7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       soft_reset = 1'b0;
    logic       pll_rst, core_reset, ready, ce_12, ce_6;
    logic [1:0] state;
    logic [7:0] relock_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pll_reset_seq #(
        .PLL_RST_CYCLES      (PR),
        .LOCK_TIMEOUT_CYCLES (TO),
        .LOCK_STABLE_CYCLES  (ST),
        .CNT_W               (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pll_locked   (pll_locked),
        .soft_reset   (soft_reset),
        .pll_rst      (pll_rst),
        .core_reset   (core_reset),
        .ready        (ready),
        .ce_12        (ce_12),
        .ce_6         (ce_6),
        .state        (state),
        .relock_count (relock_count)
    );

    // Behavioural reference: phase number, cycles already spent in the
    // phase, 1-based RUN cycle number and lock-loss tally. The lock input is
    // seen two cycles late.
    logic m_s1, m_lk;
    int   m_phase, m_t, m_run_n, m_relock;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 <= 1'b0; m_lk <= 1'b0;
            m_phase <= 0; m_t <= 0; m_run_n <= 0; m_relock <= 0;
        end else begin
            m_s1 <= pll_locked;
            m_lk <= m_s1;
            if (m_phase == 0) begin
                if (m_t + 1 == PR) begin m_phase <= 1; m_t <= 0; end
                else m_t <= m_t + 1;
            end else if (m_phase == 1) begin
                if (m_lk) begin m_phase <= 2; m_t <= 0; end
                else if (m_t + 1 == TO) begin m_phase <= 0; m_t <= 0; end
                else m_t <= m_t + 1;
            end else if (m_phase == 2) begin
                if (!m_lk) begin m_phase <= 1; m_t <= 0; end
                else if (soft_reset) m_t <= 0;
                else if (m_t + 1 == ST) begin m_phase <= 3; m_t <= 0; m_run_n <= 1; end
                else m_t <= m_t + 1;
            end else begin
                if (!m_lk) begin
                    m_phase <= 0; m_t <= 0; m_run_n <= 0;
                    m_relock <= (m_relock < 255) ? m_relock + 1 : 255;
                end else if (soft_reset) begin
                    m_phase <= 2; m_t <= 0; m_run_n <= 0;
                end else m_run_n <= m_run_n + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bring_to_run();
        int n = 0;
        while (!ready && n < 500) begin tick(); n++; end
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL run_entry: ready=%0b after %0d cycles, required 1", ready, n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pll_locked = 1'b1; soft_reset = 1'b0;
        repeat (3) tick();
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL rst_state: got %0d want 0", state); end
        checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL rst_pll_rst: got %0b want 1", pll_rst); end
        checks++; if (core_reset !== 1'b1) begin failures++; $display("FAIL rst_core_reset: got %0b want 1", core_reset); end
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL rst_ready: got %0b want 0", ready); end
        checks++; if ({ce_12, ce_6} !== 2'b00) begin failures++; $display("FAIL rst_ce: got %b want 00", {ce_12, ce_6}); end
        checks++; if (relock_count !== 8'd0) begin failures++; $display("FAIL rst_relock: got %0d want 0", relock_count); end
        $display("test_reset: outputs checked under reset");
    endtask

    task automatic test_powerup();
        int n;
        bit early = 0;
        rst_n = 1'b1;
        n = 0;
        while (pll_rst === 1'b1 && n < 100) begin tick(); n++; if (ce_12 | ce_6) early = 1; end
        checks++; if (n != PR) begin failures++; $display("FAIL pllrst_len: got %0d want %0d", n, PR); end
        checks++; if (state !== 2'd1) begin failures++; $display("FAIL wait_entry: got %0d want 1", state); end
        n = 0;
        while (state === 2'd1 && n < 100) begin tick(); n++; if (ce_12 | ce_6) early = 1; end
        checks++; if (n != 1) begin failures++; $display("FAIL wait_len: got %0d want 1", n); end
        n = 0;
        while (state === 2'd2 && n < 100) begin
            if (ready | ce_12 | ce_6) early = 1;
            tick(); n++;
        end
        checks++; if (n != ST) begin failures++; $display("FAIL stable_len: got %0d want %0d", n, ST); end
        checks++; if ({state, ready, core_reset} !== 4'b1110) begin
            failures++; $display("FAIL run_outputs: state=%0d ready=%0b core_reset=%0b want 3 1 0", state, ready, core_reset);
        end
        checks++; if (early) begin failures++; $display("FAIL early_outputs: enables/ready seen before RUN (got 1 want 0)"); end
        $display("test_powerup: pll_rst %0d cycles, stable %0d cycles", PR, ST);
    endtask

    task automatic test_enables();
        for (int k = 1; k <= 24; k++) begin
            checks++;
            if ({ce_12, ce_6} !== {(k % 4 == 0), (k % 8 == 0)}) begin
                failures++;
                $display("FAIL enables run_cycle=%0d: got ce_12=%0b ce_6=%0b want %0b %0b",
                         k, ce_12, ce_6, (k % 4 == 0), (k % 8 == 0));
            end
            tick();
        end
        $display("test_enables: 24 RUN cycles checked");
    endtask

    task automatic test_soft_reset();
        int n;
        bit pr_seen = 0;
        soft_reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (state !== 2'd2 || pll_rst !== 1'b0) begin
                failures++; $display("FAIL soft_hold cycle=%0d: state=%0d pll_rst=%0b want 2 0", i, state, pll_rst);
            end
        end
        soft_reset = 1'b0;
        n = 0;
        while (!ready && n < 100) begin tick(); n++; pr_seen |= pll_rst; end
        checks++; if (n != ST) begin failures++; $display("FAIL soft_rerun: got %0d want %0d", n, ST); end
        checks++; if (pr_seen) begin failures++; $display("FAIL soft_pll_rst: got 1 want 0"); end
        for (int k = 1; k <= 8; k++) begin
            checks++;
            if (ce_6 !== (k == 8)) begin failures++; $display("FAIL soft_ce6 run_cycle=%0d: got %0b want %0b", k, ce_6, (k == 8)); end
            tick();
        end
        $display("test_soft_reset: RUN re-entered after soft_reset");
    endtask

    task automatic test_unstable();
        int n;
        bit saw_wait = 0;
        bit early = 0;
        soft_reset = 1'b1; tick(); soft_reset = 1'b0;
        tick(); tick();
        pll_locked = 1'b0;
        repeat (3) begin tick(); if (ready) early = 1; end
        pll_locked = 1'b1;
        n = 0;
        while (state !== 2'd2 && n < 50) begin
            if (state === 2'd1) saw_wait = 1;
            if (ready) early = 1;
            tick(); n++;
        end
        n = 0;
        while (state === 2'd2 && n < 100) begin if (ready) early = 1; tick(); n++; end
        checks++; if (!saw_wait) begin failures++; $display("FAIL unstable_wait: WAIT seen=0 want 1"); end
        checks++; if (n != ST) begin failures++; $display("FAIL unstable_restart: got %0d want %0d", n, ST); end
        checks++; if (early) begin failures++; $display("FAIL unstable_early_ready: got 1 want 0"); end
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL unstable_run: ready=%0b want 1", ready); end
        $display("test_unstable: lock glitch in STABLE restarted qualification");
    endtask

    task automatic test_timeout();
        int n;
        pll_locked = 1'b0;
        n = 0;
        while (state !== 2'd0 && n < 20) begin tick(); n++; end
        checks++; if (n != 3) begin failures++; $display("FAIL loss_latency: got %0d want 3", n); end
        checks++; if ({core_reset, ready, ce_12, ce_6} !== 4'b1000) begin
            failures++; $display("FAIL loss_outputs: got %b want 1000", {core_reset, ready, ce_12, ce_6});
        end
        for (int rep = 0; rep < 2; rep++) begin
            n = 0;
            while (state === 2'd0 && n < 50) begin tick(); n++; end
            checks++; if (n != PR) begin failures++; $display("FAIL retry_pllrst rep=%0d: got %0d want %0d", rep, n, PR); end
            n = 0;
            while (state === 2'd1 && n < 200) begin tick(); n++; end
            checks++; if (n != TO) begin failures++; $display("FAIL retry_wait rep=%0d: got %0d want %0d", rep, n, TO); end
        end
        n = 0;
        while (state === 2'd0 && n < 50) begin tick(); n++; end
        repeat (20) tick();
        pll_locked = 1'b1;
        n = 0;
        while (state !== 2'd2 && n < 20) begin tick(); n++; end
        checks++; if (n != 3) begin failures++; $display("FAIL midwait_lock: got %0d want 3", n); end
        bring_to_run();
        $display("test_timeout: WAIT timeouts and retries checked");
    endtask

    task automatic test_random();
        int seg_left = 0;
        int r;
        int nfail_print = 0;
        logic [14:0] got, exp;
        for (int c = 0; c < 3000; c++) begin
            exp = {m_phase[1:0], (m_phase == 0), (m_phase != 3), (m_phase == 3),
                   (m_phase == 3) && (m_run_n % 4 == 0), (m_phase == 3) && (m_run_n % 8 == 0),
                   m_relock[7:0]};
            got = {state, pll_rst, core_reset, ready, ce_12, ce_6, relock_count};
            checks++;
            if (got !== exp) begin
                failures++;
                if (nfail_print < 10) begin
                    nfail_print++;
                    $display("FAIL random cycle=%0d: got %h want %h", c, got, exp);
                end
            end
            if (seg_left == 0) begin
                r = $urandom_range(0, 99);
                if (r < 70) begin pll_locked = 1'b1; seg_left = $urandom_range(1, 40); end
                else if (r < 90) begin pll_locked = 1'b0; seg_left = $urandom_range(1, 6); end
                else begin pll_locked = 1'b0; seg_left = $urandom_range(60, 140); end
            end
            seg_left--;
            soft_reset = ($urandom_range(0, 99) < 3);
            tick();
        end
        pll_locked = 1'b1; soft_reset = 1'b0;
        bring_to_run();
        $display("test_random: 3000 cycles compared against reference");
    endtask

    task automatic test_relock();
        int n;
        int want;
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        pll_locked = 1'b1;
        bring_to_run();
        checks++; if (relock_count !== 8'd0) begin failures++; $display("FAIL relock_start: got %0d want 0", relock_count); end
        for (int i = 1; i <= 300; i++) begin
            pll_locked = 1'b0;
            n = 0;
            while (state !== 2'd0 && n < 20) begin tick(); n++; end
            want = (i < 255) ? i : 255;
            checks++;
            if (state !== 2'd0 || relock_count !== want[7:0]) begin
                failures++;
                $display("FAIL relock i=%0d: state=%0d count=%0d want 0 %0d", i, state, relock_count, want);
            end
            pll_locked = 1'b1;
            bring_to_run();
            $display("relock %0d: count=%0d", i, relock_count);
        end
    endtask

    task automatic test_async_reset();
        repeat (5) tick();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({state, pll_rst, core_reset, ready, ce_12, ce_6, relock_count} !== {2'd0, 5'b11000, 8'd0}) begin
            failures++;
            $display("FAIL async_reset: got state=%0d pll_rst=%0b core_reset=%0b ready=%0b ce=%b relock=%0d want 0 1 1 0 00 0",
                     state, pll_rst, core_reset, ready, {ce_12, ce_6}, relock_count);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        $display("test_async_reset: mid-RUN reset cleared outputs");
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_enables();
        test_soft_reset();
        test_unstable();
        test_timeout();
        test_random();
        test_relock();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
